// File: rtl/riscv_lsu_split.sv
// Load/store unit between MEM and the data bus: lane steering, load extension,
// and two-beat splitting of accesses that cross an XLEN word boundary.
module riscv_lsu_split #(
    parameter int XLEN          = 32,
    parameter int ALEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ALEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ALEN-1:0]     bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_fault
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic [2:0]      state;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [ALEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            split_q;
    logic [XLEN-1:0] rdata0_q;
    logic [XLEN-1:0] rdata1_q;

    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = raw[7:0];
        h = raw[15:0];
        w = raw[31:0];
        case (f3)
            3'b000:  extend_load = XLEN'(b);
            3'b001:  extend_load = XLEN'(h);
            3'b010:  extend_load = XLEN'(w);
            3'b100:  extend_load = XLEN'(raw[7:0]);
            3'b101:  extend_load = XLEN'(raw[15:0]);
            3'b110:  extend_load = XLEN'(raw[31:0]);
            default: extend_load = raw;
        endcase
    endfunction

    // In IDLE the live request drives the lane math; afterwards the latched copy does.
    logic            src_we;
    logic [2:0]      src_f3;
    logic [ALEN-1:0] src_addr;
    logic [XLEN-1:0] src_wdata;
    always_comb begin
        src_we    = we_q;
        src_f3    = funct3_q;
        src_addr  = addr_q;
        src_wdata = wdata_q;
        if (state == S_IDLE) begin
            src_we    = req_we;
            src_f3    = req_funct3;
            src_addr  = req_addr;
            src_wdata = req_wdata;
        end
    end

    logic [OFS-1:0]  ofs;
    logic [3:0]      size;
    logic [NB-1:0]   sz_mask;
    logic [4:0]      end_pos;
    logic            split;
    logic            illegal;
    logic            misal;
    logic [ALEN-1:0] beat0_addr;
    logic [ALEN-1:0] beat1_addr;
    logic [XLEN-1:0] r0_eff;
    logic [XLEN-1:0] r1_eff;
    logic [XLEN-1:0] raw;

    assign ofs = src_addr[OFS-1:0];

    always_comb begin
        case (src_f3[1:0])
            2'd0:    size = 4'd1;
            2'd1:    size = 4'd2;
            2'd2:    size = 4'd4;
            default: size = 4'd8;
        endcase
        sz_mask = '0;
        for (int i = 0; i < NB; i++) sz_mask[i] = (i < int'(size));
    end

    assign end_pos    = 5'(ofs) + 5'(size);
    assign split      = MISALIGNED_EN && (end_pos > 5'(NB));
    assign illegal    = (src_f3 == 3'b111) || (src_we && src_f3[2]) ||
                        ((XLEN == 32) && ((src_f3 == 3'b011) || (src_f3 == 3'b110)));
    assign misal      = !MISALIGNED_EN && ((src_addr[2:0] & 3'(size - 4'd1)) != 3'b000);
    assign beat0_addr = {src_addr[ALEN-1:OFS], {OFS{1'b0}}};
    assign beat1_addr = beat0_addr + ALEN'(NB);

    // The beat currently being acknowledged is taken straight off the bus.
    assign r0_eff = (state == S_WAIT0) ? bus_rdata : rdata0_q;
    assign r1_eff = (state == S_WAIT1) ? bus_rdata : rdata1_q;
    assign raw    = (r0_eff >> {ofs, 3'b000}) | (r1_eff << (XLEN - 8 * int'(ofs)));

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            split_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        split_q  <= split;
                        if (illegal || misal) begin
                            state     <= S_FAULT;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                        end else begin
                            state     <= S_REQ0;
                            bus_valid <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= beat0_addr;
                            bus_be    <= sz_mask << ofs;
                            bus_wdata <= src_wdata << {ofs, 3'b000};
                        end
                    end
                end
                S_REQ0: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state     <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (bus_rvalid) begin
                        rdata0_q <= bus_rdata;
                        if (split_q) begin
                            state     <= S_REQ1;
                            bus_valid <= 1'b1;
                            bus_addr  <= beat1_addr;
                            bus_be    <= sz_mask >> (NB - int'(ofs));
                            bus_wdata <= src_wdata >> (XLEN - 8 * int'(ofs));
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= we_q ? '0 : extend_load(raw, funct3_q);
                        end
                    end
                end
                S_REQ1: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state     <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (bus_rvalid) begin
                        rdata1_q  <= bus_rdata;
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? '0 : extend_load(raw, funct3_q);
                    end
                end
                S_RESP:  state <= S_IDLE;
                S_FAULT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
